multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multicycle MIPS main controller: sequences one shared datapath (ALU, register file, single unified memory)
//  through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states per instruction. Decodes the same opcode set as the
//  single-cycle control unit (R, ADDI, BEQ, J, LW, SW). Stalls on a variable-latency memory handshake.
//  Flags illegal opcodes and memory timeouts.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting for mem_ready before abort (1..255)
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst_n          in   1      synchronous active-low reset
//  opcode         in   6      IR[31:26], valid from DECODE onward
//  zero           in   1      ALU zero flag (BEQ resolution)
//  mem_ready      in   1      memory completes current read/write this cycle
//  pc_write       out  1      unconditional PC load
//  pc_write_cond  out  1      PC load if zero (BEQ)
//  pc_src         out  2      0 ALU result, 1 ALUOut reg, 2 jump target
//  iord           out  1      memory address: 0 PC, 1 ALUOut
//  mem_read       out  1      memory read request (held until mem_ready)
//  mem_write      out  1      memory write request (held until mem_ready)
//  ir_write       out  1      load instruction register
//  mem_2_reg      out  1      writeback source: 1 MDR, 0 ALUOut
//  reg_dst        out  1      1 rd, 0 rt
//  reg_write      out  1      register file write enable
//  alu_src_a      out  1      0 PC, 1 rs
//  alu_src_b      out  2      0 rt, 1 const 4, 2 sign-ext imm, 3 sign-ext imm<<2
//  alu_op         out  2      0 add, 1 sub, 2 R-type (funct decode)
//  illegal_op     out  1      1-cycle pulse: unknown opcode seen in DECODE
//  mem_timeout    out  1      1-cycle pulse: MEM_TIMEOUT cycles without mem_ready
//  retired        out  CNT_W  count of completed instructions, wraps at 2^CNT_W
//  state_o        out  4      current state encoding (debug)
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=FETCH, wait counter=0, retired=0; all outputs derive from state,
//   so in FETCH: mem_read=1, iord=0, others 0. Reset mid-wait abandons the access silently.
//  States/encodings: FETCH0 DECODE1 MEM_ADDR2 MEM_RD3 MEM_WB4 MEM_WR5 EXEC_R6 R_WB7 EXEC_I8 I_WB9 BRANCH10 JUMP11.
//  FETCH: mem_read=1, iord=0; on mem_ready: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0
//   (PC+4), -> DECODE; else stay.
//  DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target precompute). Next: LW/SW->MEM_ADDR, R->EXEC_R,
//   ADDI->EXEC_I, BEQ->BRANCH, J->JUMP, other->FETCH with illegal_op=1 (not retired).
//  MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0; LW->MEM_RD, SW->MEM_WR.
//  MEM_RD: mem_read=1, iord=1; mem_ready -> MEM_WB.   MEM_WR: mem_write=1, iord=1; mem_ready -> FETCH, retire.
//  MEM_WB: reg_write=1, reg_dst=0, mem_2_reg=1 -> FETCH, retire.
//  EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=2 -> R_WB.  R_WB: reg_write=1, reg_dst=1, mem_2_reg=0 -> FETCH, retire.
//  EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=0 -> I_WB.  I_WB: reg_write=1, reg_dst=0, mem_2_reg=0 -> FETCH, retire.
//  BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_src=1 -> FETCH, retire (taken or not).
//  JUMP: pc_write=1, pc_src=2 -> FETCH, retire.
//  Cycle counts with mem_ready always 1: R/ADDI/SW 4, LW 5, BEQ/J 3.
//  Memory handshake: request held constant while waiting; wait counter increments each non-ready cycle in a
//   mem state, clears on state exit. Counter reaching MEM_TIMEOUT-1 with mem_ready=0: mem_timeout=1,
//   -> FETCH, no retire, no register/PC write. mem_ready on the timeout cycle wins (normal completion).
//  retired increments by 1 on the clock edge leaving a retiring state; wraps all-ones -> 0.
//  Outputs are pure functions of state (and mem_ready for gated writes: ir_write/pc_write in FETCH).
// TESTING
//  R-type op=0x00, mem_ready=1 -> states 0,1,6,7,0; reg_write=1 with reg_dst=1 in state 7; retired=1.
//  LW op=0x23, mem_ready delayed 3 cycles in MEM_RD -> mem_read/iord held 3 cycles, then 4,0; total 8 cycles.
//  BEQ op=0x04 zero=1 -> pc_write_cond=1,pc_src=1 in state 10; J op=0x02 -> pc_write=1,pc_src=2 in state 11.
//  op=0x3F -> illegal_op pulse in DECODE, back to FETCH, retired unchanged.
//  MEM_TIMEOUT=4, mem_ready=0 in FETCH -> mem_timeout pulse on 4th cycle, stay FETCH, ir_write never 1.
//  rst_n=0 during MEM_WR wait -> next cycle state_o=0, mem_write=0, retired=0.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - controller-to-datapath bundle for the multicycle MIPS controller
interface multicycle_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_src;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_2_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             illegal_op;
    logic             mem_timeout;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state_o;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
               mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               illegal_op, mem_timeout, retired, state_o
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
               mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               illegal_op, mem_timeout, retired, state_o
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS main controller with memory stall and timeout
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_control_fsm_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] retired_q;
    logic             in_mem;
    logic             timeout_hit;
    logic             retire;
    logic             known_op;
    logic             unused_zero;

    // Branch resolution happens in the datapath via pc_write_cond, so zero is only passed through.
    assign unused_zero = bus.zero;

    always_comb begin
        in_mem      = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
        timeout_hit = in_mem && !bus.mem_ready && (wait_cnt == WAIT_LAST);
        retire      = ((state == S_MEM_WR) && bus.mem_ready) || (state == S_MEM_WB) ||
                      (state == S_R_WB) || (state == S_I_WB) || (state == S_BRANCH) ||
                      (state == S_JUMP);
        known_op    = (bus.opcode == OP_R) || (bus.opcode == OP_J) || (bus.opcode == OP_BEQ) ||
                      (bus.opcode == OP_ADDI) || (bus.opcode == OP_LW) || (bus.opcode == OP_SW);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            wait_cnt  <= 8'd0;
            retired_q <= '0;
        end else begin
            // Counter only runs while stalled; any exit (ready or timeout) restarts it.
            if (in_mem && !bus.mem_ready && !timeout_hit) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end
            if (retire) begin
                retired_q <= retired_q + 1'b1;
            end
            case (state)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW: state <= S_MEM_ADDR;
                        OP_R:         state <= S_EXEC_R;
                        OP_ADDI:      state <= S_EXEC_I;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_J:         state <= S_JUMP;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEM_ADDR: begin
                    if (bus.opcode == OP_LW) begin
                        state <= S_MEM_RD;
                    end else if (bus.opcode == OP_SW) begin
                        state <= S_MEM_WR;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_MEM_RD: begin
                    if (bus.mem_ready) begin
                        state <= S_MEM_WB;
                    end else if (timeout_hit) begin
                        state <= S_FETCH;
                    end
                end
                S_MEM_WR: begin
                    if (bus.mem_ready || timeout_hit) begin
                        state <= S_FETCH;
                    end
                end
                S_EXEC_R: state <= S_R_WB;
                S_EXEC_I: state <= S_I_WB;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Moore decode of the registered state; only FETCH write strobes look at mem_ready.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_src        = 2'd0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_2_reg     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.alu_op        = 2'd0;
        case (state)
            S_FETCH: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_write  = 1'b1;
                    bus.pc_write  = 1'b1;
                    bus.alu_src_b = 2'd1;
                end
            end
            S_DECODE:   bus.alu_src_b = 2'd3;
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write = 1'b1;
                bus.mem_2_reg = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'd2;
            end
            S_R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
            end
            S_I_WB:   bus.reg_write = 1'b1;
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'd1;
                bus.pc_write_cond = 1'b1;
                bus.pc_src        = 2'd1;
            end
            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 2'd2;
            end
            default: ;
        endcase
        bus.illegal_op  = (state == S_DECODE) && !known_op;
        bus.mem_timeout = timeout_hit;
        bus.retired     = retired_q;
        bus.state_o     = state;
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed vector bench for multicycle_control_fsm
module tb_multicycle_control_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.CNT_W(32)) ifc ();

    multicycle_control_fsm #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    typedef struct {
        logic        rst_n;
        logic [5:0]  opcode;
        logic        zero;
        logic        mem_ready;
        logic [3:0]  exp_state;
        logic [15:0] exp_cw;
        logic        exp_ill;
        logic        exp_to;
        logic [31:0] exp_ret;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write, ir_write,
    //  mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op}
    function automatic logic [15:0] cw(input logic pcw, input logic pcwc, input logic [1:0] psrc,
                                       input logic iord, input logic mrd, input logic mwr,
                                       input logic irw, input logic m2r, input logic rdst,
                                       input logic rw, input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop);
        return {pcw, pcwc, psrc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop};
    endfunction

    function automatic vec_t mk(input logic r, input logic [5:0] op, input logic z, input logic mr,
                                input logic [3:0] st, input logic [15:0] c, input logic ill,
                                input logic to, input logic [31:0] ret);
        vec_t v;
        v.rst_n = r; v.opcode = op; v.zero = z; v.mem_ready = mr;
        v.exp_state = st; v.exp_cw = c; v.exp_ill = ill; v.exp_to = to; v.exp_ret = ret;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        logic [15:0] act_cw;
        @(negedge clk);
        rst_n         = v.rst_n;
        ifc.opcode    = v.opcode;
        ifc.zero      = v.zero;
        ifc.mem_ready = v.mem_ready;
        #1;
        n_vec++;
        act_cw = {ifc.pc_write, ifc.pc_write_cond, ifc.pc_src, ifc.iord, ifc.mem_read,
                  ifc.mem_write, ifc.ir_write, ifc.mem_2_reg, ifc.reg_dst, ifc.reg_write,
                  ifc.alu_src_a, ifc.alu_src_b, ifc.alu_op};
        if (ifc.state_o !== v.exp_state) begin
            n_bad++;
            $display("FAIL vec%0d state: got %0d want %0d", idx, ifc.state_o, v.exp_state);
        end
        if (act_cw !== v.exp_cw) begin
            n_bad++;
            $display("FAIL vec%0d ctrl: got %h want %h", idx, act_cw, v.exp_cw);
        end
        if (ifc.illegal_op !== v.exp_ill) begin
            n_bad++;
            $display("FAIL vec%0d illegal_op: got %b want %b", idx, ifc.illegal_op, v.exp_ill);
        end
        if (ifc.mem_timeout !== v.exp_to) begin
            n_bad++;
            $display("FAIL vec%0d mem_timeout: got %b want %b", idx, ifc.mem_timeout, v.exp_to);
        end
        if (ifc.retired !== v.exp_ret) begin
            n_bad++;
            $display("FAIL vec%0d retired: got %0d want %0d", idx, ifc.retired, v.exp_ret);
        end
    endtask

    initial begin
        logic [15:0] f_nr, f_r, dec, maddr, mrd, mwb, mwr, exr, rwb, exi, iwb, br, jmp;
        f_nr  = cw(0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
        f_r   = cw(1, 0, 2'd0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd1, 2'd0);
        dec   = cw(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0);
        maddr = cw(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0);
        mrd   = cw(0, 0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
        mwb   = cw(0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0);
        mwr   = cw(0, 0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
        exr   = cw(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2);
        rwb   = cw(0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0);
        exi   = cw(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0);
        iwb   = cw(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0);
        br    = cw(0, 1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1);
        jmp   = cw(1, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);

        // reset state, then R-type
        vecs.push_back(mk(1, 6'h00, 0, 0, 4'd0,  f_nr,  0, 0, 0));
        vecs.push_back(mk(1, 6'h00, 0, 1, 4'd0,  f_r,   0, 0, 0));
        vecs.push_back(mk(1, 6'h00, 0, 1, 4'd1,  dec,   0, 0, 0));
        vecs.push_back(mk(1, 6'h00, 0, 1, 4'd6,  exr,   0, 0, 0));
        vecs.push_back(mk(1, 6'h00, 0, 1, 4'd7,  rwb,   0, 0, 0));
        // LW with three stalled MEM_RD cycles; ready arrives on the would-be timeout cycle
        vecs.push_back(mk(1, 6'h23, 0, 1, 4'd0,  f_r,   0, 0, 1));
        vecs.push_back(mk(1, 6'h23, 0, 1, 4'd1,  dec,   0, 0, 1));
        vecs.push_back(mk(1, 6'h23, 0, 1, 4'd2,  maddr, 0, 0, 1));
        vecs.push_back(mk(1, 6'h23, 0, 0, 4'd3,  mrd,   0, 0, 1));
        vecs.push_back(mk(1, 6'h23, 0, 0, 4'd3,  mrd,   0, 0, 1));
        vecs.push_back(mk(1, 6'h23, 0, 0, 4'd3,  mrd,   0, 0, 1));
        vecs.push_back(mk(1, 6'h23, 0, 1, 4'd3,  mrd,   0, 0, 1));
        vecs.push_back(mk(1, 6'h23, 0, 1, 4'd4,  mwb,   0, 0, 1));
        // SW
        vecs.push_back(mk(1, 6'h2B, 0, 1, 4'd0,  f_r,   0, 0, 2));
        vecs.push_back(mk(1, 6'h2B, 0, 1, 4'd1,  dec,   0, 0, 2));
        vecs.push_back(mk(1, 6'h2B, 0, 1, 4'd2,  maddr, 0, 0, 2));
        vecs.push_back(mk(1, 6'h2B, 0, 1, 4'd5,  mwr,   0, 0, 2));
        // ADDI
        vecs.push_back(mk(1, 6'h08, 0, 1, 4'd0,  f_r,   0, 0, 3));
        vecs.push_back(mk(1, 6'h08, 0, 1, 4'd1,  dec,   0, 0, 3));
        vecs.push_back(mk(1, 6'h08, 0, 1, 4'd8,  exi,   0, 0, 3));
        vecs.push_back(mk(1, 6'h08, 0, 1, 4'd9,  iwb,   0, 0, 3));
        // BEQ taken, then J
        vecs.push_back(mk(1, 6'h04, 1, 1, 4'd0,  f_r,   0, 0, 4));
        vecs.push_back(mk(1, 6'h04, 1, 1, 4'd1,  dec,   0, 0, 4));
        vecs.push_back(mk(1, 6'h04, 1, 1, 4'd10, br,    0, 0, 4));
        vecs.push_back(mk(1, 6'h02, 0, 1, 4'd0,  f_r,   0, 0, 5));
        vecs.push_back(mk(1, 6'h02, 0, 1, 4'd1,  dec,   0, 0, 5));
        vecs.push_back(mk(1, 6'h02, 0, 1, 4'd11, jmp,   0, 0, 5));
        // illegal opcode, then FETCH timeout on the 4th stalled cycle
        vecs.push_back(mk(1, 6'h3F, 0, 1, 4'd0,  f_r,   0, 0, 6));
        vecs.push_back(mk(1, 6'h3F, 0, 1, 4'd1,  dec,   1, 0, 6));
        vecs.push_back(mk(1, 6'h3F, 0, 0, 4'd0,  f_nr,  0, 0, 6));
        vecs.push_back(mk(1, 6'h3F, 0, 0, 4'd0,  f_nr,  0, 0, 6));
        vecs.push_back(mk(1, 6'h3F, 0, 0, 4'd0,  f_nr,  0, 0, 6));
        vecs.push_back(mk(1, 6'h3F, 0, 0, 4'd0,  f_nr,  0, 1, 6));
        vecs.push_back(mk(1, 6'h3F, 0, 0, 4'd0,  f_nr,  0, 0, 6));

        ifc.opcode    = 6'h00;
        ifc.zero      = 1'b0;
        ifc.mem_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // reset during a stalled SW write abandons it
        apply(mk(1, 6'h2B, 0, 1, 4'd0, f_r,   0, 0, 6), 100);
        apply(mk(1, 6'h2B, 0, 1, 4'd1, dec,   0, 0, 6), 101);
        apply(mk(1, 6'h2B, 0, 1, 4'd2, maddr, 0, 0, 6), 102);
        apply(mk(1, 6'h2B, 0, 0, 4'd5, mwr,   0, 0, 6), 103);
        apply(mk(0, 6'h2B, 0, 0, 4'd5, mwr,   0, 0, 6), 104);
        apply(mk(1, 6'h2B, 0, 0, 4'd0, f_nr,  0, 0, 0), 105);

        // SW write that times out: no retire, back to FETCH
        apply(mk(1, 6'h2B, 0, 1, 4'd0, f_r,   0, 0, 0), 200);
        apply(mk(1, 6'h2B, 0, 1, 4'd1, dec,   0, 0, 0), 201);
        apply(mk(1, 6'h2B, 0, 1, 4'd2, maddr, 0, 0, 0), 202);
        apply(mk(1, 6'h2B, 0, 0, 4'd5, mwr,   0, 0, 0), 203);
        apply(mk(1, 6'h2B, 0, 0, 4'd5, mwr,   0, 0, 0), 204);
        apply(mk(1, 6'h2B, 0, 0, 4'd5, mwr,   0, 0, 0), 205);
        apply(mk(1, 6'h2B, 0, 0, 4'd5, mwr,   0, 1, 0), 206);
        apply(mk(1, 6'h2B, 0, 0, 4'd0, f_nr,  0, 0, 0), 207);
        apply(mk(1, 6'h2B, 0, 1, 4'd0, f_r,   0, 0, 0), 208);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
